// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Desc     : EX-stage branch resolution with held redirect handshake, timed
//            wrong-path flush and wrapping branch statistics counters.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [2:0]       ex_br_op,
    input  logic             zero,
    input  logic [31:0]      ex_pc_plus4,
    input  logic [31:0]      ex_offset,
    input  logic [25:0]      ex_index,
    input  logic [31:0]      ex_jr_target,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             stall_ex,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] c_op_beq     = 3'b001;
    localparam logic [2:0] c_op_bne     = 3'b010;
    localparam logic [2:0] c_op_j       = 3'b011;
    localparam logic [2:0] c_op_jr      = 3'b100;
    localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_redirect_pc;
    logic [31:0]       w_redirect_pc_nxt;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        w_flush_cnt_nxt;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  w_br_cnt_nxt;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  w_taken_cnt_nxt;

    logic              w_is_cond;
    logic              w_taken;
    logic [31:0]       w_target;

    // Decode: reserved opcodes fall into the default arm and act as "none".
    always_comb begin
        w_is_cond = 1'b0;
        w_taken   = 1'b0;
        w_target  = ex_pc_plus4 + (ex_offset << 2);
        case (ex_br_op)
            c_op_beq: begin
                w_is_cond = 1'b1;
                w_taken   = zero;
            end
            c_op_bne: begin
                w_is_cond = 1'b1;
                w_taken   = ~zero;
            end
            c_op_j: begin
                w_taken  = 1'b1;
                w_target = {ex_pc_plus4[31:28], ex_index, 2'b00};
            end
            c_op_jr: begin
                w_taken  = 1'b1;
                w_target = ex_jr_target;
            end
            default: begin
                w_is_cond = 1'b0;
                w_taken   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_redirect_pc_nxt = r_redirect_pc;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_br_cnt_nxt      = r_br_cnt;
        w_taken_cnt_nxt   = r_taken_cnt;
        case (r_state)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (w_is_cond) begin
                        w_br_cnt_nxt = r_br_cnt + CNT_W'(1);
                        if (w_taken) begin
                            w_taken_cnt_nxt = r_taken_cnt + CNT_W'(1);
                        end
                    end
                    if (w_taken) begin
                        w_redirect_pc_nxt = w_target;
                        w_state_nxt       = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                // Target stays frozen until fetch takes it.
                if (redirect_ready) begin
                    w_flush_cnt_nxt = c_flush_init;
                    w_state_nxt     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_redirect_pc <= 32'd0;
            r_flush_cnt   <= 4'd0;
            r_br_cnt      <= '0;
            r_taken_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_br_cnt      <= w_br_cnt_nxt;
            r_taken_cnt   <= w_taken_cnt_nxt;
        end
    end

    // Handshake/flush outputs decode straight from state so reset clears them at once.
    assign redirect_valid = (r_state == ST_REDIRECT);
    assign redirect_pc    = r_redirect_pc;
    assign flush          = (r_state == ST_FLUSH);
    assign stall_ex       = (r_state != ST_IDLE);
    assign br_cnt         = r_br_cnt;
    assign taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Desc     : Directed bench; u0 uses default parameters, u1 uses
//            FLUSH_CYCLES=1 / CNT_W=4 and shares every input with u0.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_br_op;
    logic        zero;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_offset;
    logic [25:0] ex_index;
    logic [31:0] ex_jr_target;
    logic        redirect_ready;

    logic        valid0, flush0, stall0;
    logic [31:0] pc0, br0, tk0;
    logic        valid1, flush1, stall1;
    logic [31:0] pc1;
    logic [3:0]  br1, tk1;

    int n_checks;
    int n_fail;

    branch_resolve_unit u0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_op(ex_br_op),
        .zero(zero), .ex_pc_plus4(ex_pc_plus4), .ex_offset(ex_offset),
        .ex_index(ex_index), .ex_jr_target(ex_jr_target),
        .redirect_ready(redirect_ready), .redirect_valid(valid0),
        .redirect_pc(pc0), .flush(flush0), .stall_ex(stall0),
        .br_cnt(br0), .taken_cnt(tk0)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_op(ex_br_op),
        .zero(zero), .ex_pc_plus4(ex_pc_plus4), .ex_offset(ex_offset),
        .ex_index(ex_index), .ex_jr_target(ex_jr_target),
        .redirect_ready(redirect_ready), .redirect_valid(valid1),
        .redirect_pc(pc1), .flush(flush1), .stall_ex(stall1),
        .br_cnt(br1), .taken_cnt(tk1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic f, input logic s);
        chk({tag, "_valid0"}, {31'd0, valid0}, {31'd0, v});
        chk({tag, "_flush0"}, {31'd0, flush0}, {31'd0, f});
        chk({tag, "_stall0"}, {31'd0, stall0}, {31'd0, s});
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        ex_valid       = 1'b0;
        ex_br_op       = 3'b000;
        zero           = 1'b0;
        ex_pc_plus4    = 32'd0;
        ex_offset      = 32'd0;
        ex_index       = 26'd0;
        ex_jr_target   = 32'd0;
        redirect_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_pc0", pc0, 32'd0);
        chk("rst_br0", br0, 32'd0);
        chk("rst_tk0", tk0, 32'd0);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        rst_n = 1'b1;
        tick();

        // BEQ not taken
        ex_valid = 1'b1; ex_br_op = 3'b001; zero = 1'b0;
        tick();
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk_out("beq_nt", 1'b0, 1'b0, 1'b0);
        chk("beq_nt_br0", br0, 32'd1);
        chk("beq_nt_tk0", tk0, 32'd0);
        chk("beq_nt_br1", {28'd0, br1}, 32'd1);
        tick();
        chk("beq_nt_stall_hold", {31'd0, stall0}, 32'd0);

        // BEQ taken, backward target, ready already high
        ex_valid = 1'b1; ex_br_op = 3'b001; zero = 1'b1;
        ex_pc_plus4 = 32'h0040_0010; ex_offset = 32'hFFFF_FFFC; redirect_ready = 1'b1;
        tick();
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk_out("beq_t_r", 1'b1, 1'b0, 1'b1);
        chk("beq_t_pc0", pc0, 32'h0040_0000);
        chk("beq_t_br0", br0, 32'd2);
        chk("beq_t_tk0", tk0, 32'd1);
        tick();
        chk_out("beq_t_f1", 1'b0, 1'b1, 1'b1);
        chk("beq_t_f1_flush1", {31'd0, flush1}, 32'd1);
        tick();
        chk_out("beq_t_f2", 1'b0, 1'b1, 1'b1);
        chk("beq_t_f2_flush1", {31'd0, flush1}, 32'd0);
        chk("beq_t_f2_stall1", {31'd0, stall1}, 32'd0);
        tick();
        chk_out("beq_t_idle", 1'b0, 1'b0, 1'b0);

        // J with 5 cycles of backpressure; ex_valid pulses must be ignored
        redirect_ready = 1'b0;
        ex_valid = 1'b1; ex_br_op = 3'b011;
        ex_pc_plus4 = 32'h3000_0004; ex_index = 26'h000_0100;
        tick();
        for (int i = 0; i < 5; i++) begin
            ex_valid = (i % 2 == 0); ex_br_op = 3'b001; zero = 1'b1;
            chk_out("j_bp", 1'b1, 1'b0, 1'b1);
            chk("j_bp_pc0", pc0, 32'h3000_0400);
            chk("j_bp_pc1", pc1, 32'h3000_0400);
            tick();
        end
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk("j_bp_br0", br0, 32'd2);
        chk("j_bp_tk0", tk0, 32'd1);
        redirect_ready = 1'b1;
        tick();
        chk_out("j_acc", 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk_out("j_idle", 1'b0, 1'b0, 1'b0);
        chk("j_br0", br0, 32'd2);
        chk("j_tk0", tk0, 32'd1);

        // JR, unaligned-looking target passed as-is; u1 flushes exactly 1 cycle
        ex_valid = 1'b1; ex_br_op = 3'b100; ex_jr_target = 32'h1234_567C;
        tick();
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk("jr_pc0", pc0, 32'h1234_567C);
        chk("jr_pc1", pc1, 32'h1234_567C);
        chk("jr_valid1", {31'd0, valid1}, 32'd1);
        tick();
        chk("jr_flush1_on", {31'd0, flush1}, 32'd1);
        tick();
        chk("jr_flush1_off", {31'd0, flush1}, 32'd0);
        chk("jr_stall1_off", {31'd0, stall1}, 32'd0);
        chk("jr_flush0_on", {31'd0, flush0}, 32'd1);
        tick();
        chk_out("jr_idle", 1'b0, 1'b0, 1'b0);

        // Reserved opcode acts as none; ex_valid=0 blocks a taken BEQ
        ex_valid = 1'b1; ex_br_op = 3'b101; zero = 1'b1;
        tick();
        chk_out("rsvd", 1'b0, 1'b0, 1'b0);
        chk("rsvd_br0", br0, 32'd2);
        ex_valid = 1'b0; ex_br_op = 3'b001;
        tick();
        chk_out("novalid", 1'b0, 1'b0, 1'b0);
        chk("novalid_br0", br0, 32'd2);
        ex_br_op = 3'b000;

        // Async reset in the middle of REDIRECT
        redirect_ready = 1'b0;
        ex_valid = 1'b1; ex_br_op = 3'b011;
        tick();
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk("mid_valid0", {31'd0, valid0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_pc0", pc0, 32'd0);
        chk("mid_rst_br0", br0, 32'd0);
        chk("mid_rst_tk0", tk0, 32'd0);
        chk("mid_rst_valid1", {31'd0, valid1}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        ex_valid = 1'b1; ex_br_op = 3'b010; zero = 1'b0; redirect_ready = 1'b1;
        ex_pc_plus4 = 32'h0000_1000; ex_offset = 32'h0000_0010;
        tick();
        ex_valid = 1'b0; ex_br_op = 3'b000;
        chk("post_rst_pc0", pc0, 32'h0000_1040);
        chk_out("post_rst", 1'b1, 1'b0, 1'b1);
        chk("post_rst_br0", br0, 32'd1);
        tick();
        tick();
        tick();
        chk_out("post_rst_idle", 1'b0, 1'b0, 1'b0);

        // 15 more taken BNEs: u1 4-bit counters wrap to 0 on the 16th
        for (int i = 0; i < 15; i++) begin
            ex_valid = 1'b1; ex_br_op = 3'b010; zero = 1'b0;
            tick();
            ex_valid = 1'b0; ex_br_op = 3'b000;
            tick();
            tick();
            tick();
            if (i == 13) begin
                chk("wrap_br1_15", {28'd0, br1}, 32'd15);
                chk("wrap_tk1_15", {28'd0, tk1}, 32'd15);
            end
        end
        chk("wrap_br1", {28'd0, br1}, 32'd0);
        chk("wrap_tk1", {28'd0, tk1}, 32'd0);
        chk("wrap_br0", br0, 32'd16);
        chk("wrap_tk0", tk0, 32'd16);
        chk_out("wrap_idle", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
